// File: rtl/byte_encode.sv
// Streaming ByteEncode_d: packs NUM_COEFFS d-bit coefficients LSB-first into bytes; optional BYTE_ENCODE_RANGE_CHECK_EN adds sticky err_o.
// Latency: byte valid the cycle after the coefficient that completes it; coefficient intake stalls while a full byte is pending.
module byte_encode #(
   parameter int D          = 12,
   parameter int NUM_COEFFS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] coeff_i,
   input  logic        coeff_valid_i,
   output logic        coeff_ready_o,
   output logic [7:0]  byte_o,
   output logic        byte_valid_o,
   input  logic        byte_ready_i,
   output logic        byte_last_o,
   output logic        done_o
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
   ,
   output logic        err_o
`endif
);

   localparam int NBYTES = NUM_COEFFS * D / 8;
   localparam int BW     = (NBYTES > 2) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

   state_t          state, state_n;
   logic [19:0]     acc, acc_n;
   logic [4:0]      cnt, cnt_n;
   logic [8:0]      ccnt, ccnt_n;
   logic [BW-1:0]   bcnt, bcnt_n;
   logic [19:0]     cin;
   logic            coeff_hs, byte_hs;

   assign cin           = 20'(coeff_i[D-1:0]);
   assign coeff_ready_o = (state == FILL) && (cnt < 5'd8);
   assign byte_valid_o  = (cnt >= 5'd8);
   assign byte_o        = acc[7:0];
   assign byte_last_o   = byte_valid_o && (bcnt == BW'(NBYTES - 1));
   assign done_o        = (state == DONE);
   assign coeff_hs      = coeff_valid_i && coeff_ready_o;
   assign byte_hs       = byte_valid_o && byte_ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
         acc   <= '0;
         cnt   <= '0;
         ccnt  <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         ccnt  <= ccnt_n;
         bcnt  <= bcnt_n;
      end
   end

   // coeff_ready needs cnt < 8 and byte_valid needs cnt >= 8, so at most one handshake fires
   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      ccnt_n  = ccnt;
      bcnt_n  = bcnt;
      if (state == DONE) begin
         state_n = FILL;
         acc_n   = '0;
         cnt_n   = '0;
         ccnt_n  = '0;
         bcnt_n  = '0;
      end else if (coeff_hs) begin
         acc_n  = acc | (cin << cnt);
         cnt_n  = cnt + 5'(D);
         ccnt_n = ccnt + 9'd1;
         if (ccnt == 9'(NUM_COEFFS - 1))
            state_n = DRAIN;
      end else if (byte_hs) begin
         acc_n  = acc >> 8;
         cnt_n  = cnt - 5'd8;
         bcnt_n = bcnt + BW'(1);
         if (state == DRAIN && cnt == 5'd8)
            state_n = DONE;
      end
   end

`ifdef BYTE_ENCODE_RANGE_CHECK_EN
   localparam logic [12:0] LIMIT = (D == 12) ? 13'd3329 : 13'(1 << D);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_o <= 1'b0;
      else if (coeff_hs && ({1'b0, coeff_i} >= LIMIT))
         err_o <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_byte_encode.sv
// Directed bench for byte_encode: four instances (D = 1, 4, 10, 12) share clock and reset.
module tb_byte_encode;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] coeff [4];
   logic        cvld  [4];
   logic        crdy  [4];
   logic [7:0]  bdat  [4];
   logic        bvld  [4];
   logic        brdy  [4];
   logic        blast [4];
   logic        done  [4];
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
   logic        err   [4];
`endif

   int          cq [256];
   logic [7:0]  eb [384];
   int          tests = 0;
   int          fails = 0;
   int          lat, n, cyc;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      byte_encode #(
         .D((g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 10 : 12),
         .NUM_COEFFS(256)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .coeff_i      (coeff[g]),
         .coeff_valid_i(cvld[g]),
         .coeff_ready_o(crdy[g]),
         .byte_o       (bdat[g]),
         .byte_valid_o (bvld[g]),
         .byte_ready_i (brdy[g]),
         .byte_last_o  (blast[g]),
         .done_o       (done[g])
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
         ,
         .err_o        (err[g])
`endif
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // bit p of the stream is bit (p % d) of coefficient p / d
   function automatic logic [7:0] gold(input int d, input int k);
      logic [7:0] b;
      for (int m = 0; m < 8; m++) begin
         int p;
         p    = 8 * k + m;
         b[m] = 1'((cq[p / d] >> (p % d)) & 1);
      end
      return b;
   endfunction

   task automatic run_poly(input int s, input int d, input int ci0, input bit rnd, output int first_lat);
      int         ci, bi, nb, cy, dn, tc, tv;
      bit         stalled;
      logic [7:0] held;
      nb = 32 * d; ci = ci0; bi = 0; cy = 0; dn = 0; tc = -1; tv = -1;
      stalled = 1'b0; held = 8'h00;
      while (bi < nb && cy < 20000) begin
         @(negedge clk);
         cvld[s]  = (ci < 256);
         coeff[s] = (ci < 256) ? 12'(cq[ci]) : 12'h000;
         brdy[s]  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled) begin
            check("stall_valid", bvld[s], 1'b1);
            check("stall_byte", bdat[s], held);
         end
         if (done[s]) dn++;
         if (!bvld[s]) check("last_idle", blast[s], 1'b0);
         if (tv < 0 && bvld[s]) tv = cy;
         if (cvld[s] && crdy[s]) begin
            if (tc < 0) tc = cy;
            ci++;
         end
         stalled = bvld[s] && !brdy[s];
         held    = bdat[s];
         if (bvld[s] && brdy[s]) begin
            check($sformatf("byte%0d", bi), bdat[s], eb[bi]);
            check($sformatf("last%0d", bi), blast[s], (bi == nb - 1));
            bi++;
         end
         cy++;
      end
      check("poly_timeout", (cy < 20000), 1'b1);
      check("coeffs_taken", ci, 256);
      check("early_done", dn, 0);
      @(negedge clk);
      cvld[s] = 1'b0;
      brdy[s] = 1'b1;
      #1;
      check("done_pulse", done[s], 1'b1);
      check("ready_in_done", crdy[s], 1'b0);
      check("valid_in_done", bvld[s], 1'b0);
      @(negedge clk);
      #1;
      check("done_cleared", done[s], 1'b0);
      check("ready_again", crdy[s], 1'b1);
      brdy[s]   = 1'b0;
      first_lat = tv - tc;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         coeff[i] = '0; cvld[i] = 1'b0; brdy[i] = 1'b0;
      end
      #3;
      for (int i = 0; i < 4; i++) begin
         check("rst_ready", crdy[i], 1'b1);
         check("rst_valid", bvld[i], 1'b0);
         check("rst_byte", bdat[i], 8'h00);
         check("rst_last", blast[i], 1'b0);
         check("rst_done", done[i], 1'b0);
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
         check("rst_err", err[i], 1'b0);
`endif
      end
      @(negedge clk);
      rst = 1'b0;

      // D=1, all ones
      for (int i = 0; i < 256; i++) cq[i] = 1;
      for (int k = 0; k < 32; k++) eb[k] = 8'hFF;
      run_poly(0, 1, 0, 1'b0, lat);

      // D=4, ramp 0..15
      for (int i = 0; i < 256; i++) cq[i] = i % 16;
      for (int k = 0; k < 128; k++) eb[k] = 8'(((2 * k + 1) % 16) * 16 + (2 * k) % 16);
      run_poly(1, 4, 0, 1'b0, lat);

      // D=12, 0xABC, 0x123, zeros
      for (int i = 0; i < 256; i++) cq[i] = 0;
      cq[0] = 'hABC; cq[1] = 'h123;
      for (int k = 0; k < 384; k++) eb[k] = 8'h00;
      eb[0] = 8'hBC; eb[1] = 8'h3A; eb[2] = 8'h12;
      run_poly(3, 12, 0, 1'b0, lat);
      check("first_byte_latency", lat, 1);

      // D=10, random 12-bit values (upper bits must be dropped), random backpressure
      for (int i = 0; i < 256; i++) cq[i] = int'($urandom_range(0, 4095));
      for (int k = 0; k < 320; k++) eb[k] = gold(10, k);
      run_poly(2, 10, 0, 1'b1, lat);

      // D=12, reset after 100 coefficients, then all 0xFFF
      n = 0; cyc = 0;
      while (n < 100 && cyc < 1000) begin
         @(negedge clk);
         cvld[3] = 1'b1; coeff[3] = 12'h5A5; brdy[3] = 1'b1;
         #1;
         if (crdy[3]) n++;
         cyc++;
      end
      check("prefill_timeout", (cyc < 1000), 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_ready", crdy[3], 1'b1);
      check("midrst_valid", bvld[3], 1'b0);
      check("midrst_byte", bdat[3], 8'h00);
      cvld[3] = 1'b0; brdy[3] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) cq[i] = 'hFFF;
      for (int k = 0; k < 384; k++) eb[k] = 8'hFF;
      run_poly(3, 12, 0, 1'b0, lat);

`ifdef BYTE_ENCODE_RANGE_CHECK_EN
      check("err_idle4", err[1], 1'b0);
      for (int i = 0; i < 256; i++) cq[i] = 0;
      cq[0] = 'h1F;
      @(negedge clk);
      cvld[1] = 1'b1; coeff[1] = 12'h01F;
      #1;
      check("err_before", err[1], 1'b0);
      @(negedge clk);
      cvld[1] = 1'b0;
      #1;
      check("err_set4", err[1], 1'b1);
      for (int k = 0; k < 128; k++) eb[k] = 8'h00;
      eb[0] = 8'h0F;
      run_poly(1, 4, 1, 1'b0, lat);
      check("err_sticky", err[1], 1'b1);

      @(negedge clk);
      cvld[3] = 1'b1; coeff[3] = 12'd3328;
      @(negedge clk);
      cvld[3] = 1'b0;
      #1;
      check("err_3328", err[3], 1'b0);
      @(negedge clk);
      cvld[3] = 1'b1; coeff[3] = 12'd3329;
      @(negedge clk);
      cvld[3] = 1'b0;
      #1;
      check("err_3329", err[3], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("err_clr4", err[1], 1'b0);
      check("err_clr12", err[3], 1'b0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
